// File: rtl/wb_source_sequencer_pkg.sv
// Shared definitions for the write-back source sequencer: FSM state
// encoding and the MemtoReg slot numbering used by the multicycle datapath.
package wb_source_sequencer_pkg;

    // Sequencer states; encodings match the datapath's original write-back control.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } wbState_t;

    // MemtoReg slot numbering for the named write-back sources.
    typedef enum logic [3:0] {
        SRC_ALUOUT   = 4'd0,
        SRC_LOADSIZE = 4'd1,
        SRC_HI       = 4'd2,
        SRC_LO       = 4'd3,
        SRC_SHIFTREG = 4'd4,
        SRC_CONST    = 4'd5,
        SRC_SHL16    = 4'd6,
        SRC_B        = 4'd7,
        SRC_SIGNEXT  = 4'd8
    } wbSlot_t;

endpackage

// File: rtl/wb_source_sequencer_src_mux.sv
// Combinational N_SRC:1 write-back source select. Every possible select
// code maps to a slot: real sources pass data and valid through, the
// constant slot always answers with CONST_VAL, and codes beyond N_SRC
// answer immediately with zero so a bad select can never stall the FSM.
module wb_source_sequencer_src_mux
    import wb_source_sequencer_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          N_SRC     = 16,
    parameter int          SEL_W     = 4,
    parameter int          CONST_SRC = int'(SRC_CONST),
    parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(277)
) (
    input  logic [N_SRC*DATA_W-1:0] i_srcData,
    input  logic [N_SRC-1:0]        i_srcValid,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_ready
);

    localparam int NUM_SLOTS = 2**SEL_W;

    logic [DATA_W-1:0] w_slotData  [NUM_SLOTS];
    logic              w_slotReady [NUM_SLOTS];

    // Build a fully populated slot table so the final select is a plain index.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        if (k == CONST_SRC) begin : g_const
            assign w_slotData[k]  = CONST_VAL;
            assign w_slotReady[k] = 1'b1;
        end else if (k < N_SRC) begin : g_src
            assign w_slotData[k]  = i_srcData[k*DATA_W +: DATA_W];
            assign w_slotReady[k] = i_srcValid[k];
        end else begin : g_empty
            assign w_slotData[k]  = '0;
            assign w_slotReady[k] = 1'b1;
        end
    end

    // The constant slot's physical input lanes exist but are deliberately ignored.
    if (CONST_SRC < N_SRC) begin : g_constLanes
        logic w_unusedConst;
        assign w_unusedConst = ^{i_srcValid[CONST_SRC], i_srcData[CONST_SRC*DATA_W +: DATA_W]};
    end

    assign o_data  = w_slotData[i_sel];
    assign o_ready = w_slotReady[i_sel];

endmodule

// File: rtl/wb_source_sequencer.sv
// Registered write-back sequencer for the multicycle MIPS datapath.
// A request latches the MemtoReg select and destination, waits (bounded)
// for the chosen source to become valid, then issues exactly one
// register-file write, or gives up with a one-cycle timeout pulse.
module wb_source_sequencer
    import wb_source_sequencer_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          N_SRC     = 16,
    parameter int          SEL_W     = 4,
    parameter int          CONST_SRC = 5,
    parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(277),
    parameter int          MAX_WAIT  = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [4:0]              wb_dest,
    input  logic                    wb_req,
    output logic                    wb_busy,
    output logic                    rf_we,
    output logic [4:0]              rf_addr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    wb_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wbState_t          r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [4:0]        r_dest;
    logic [CNT_W-1:0]  r_waitCnt;
    logic              r_busy;
    logic              r_rfWe;
    logic [4:0]        r_rfAddr;
    logic [DATA_W-1:0] r_rfWdata;
    logic              r_timeout;

    logic [DATA_W-1:0] w_srcData;
    logic              w_srcReady;

    wb_source_sequencer_src_mux #(
        .DATA_W    (DATA_W),
        .N_SRC     (N_SRC),
        .SEL_W     (SEL_W),
        .CONST_SRC (CONST_SRC),
        .CONST_VAL (CONST_VAL)
    ) u_srcMux (
        .i_srcData  (src_data),
        .i_srcValid (src_valid),
        .i_sel      (r_sel),
        .o_data     (w_srcData),
        .o_ready    (w_srcReady)
    );

    // Request FSM with wait counter; timeout is raised one edge early so the
    // pulse coincides with the final WAIT cycle, and that cycle always exits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_dest    <= '0;
            r_waitCnt <= '0;
            r_busy    <= 1'b0;
            r_rfWe    <= 1'b0;
            r_rfAddr  <= '0;
            r_rfWdata <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_rfWe    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wb_req) begin
                        r_sel     <= sel;
                        r_dest    <= wb_dest;
                        r_waitCnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_waitCnt == CNT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_srcReady) begin
                        if (r_dest != 5'd0) begin
                            r_rfWdata <= w_srcData;
                            r_rfAddr  <= r_dest;
                            r_rfWe    <= 1'b1;
                        end
                        r_state <= ST_WRITE;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_ONE;
                        if (r_waitCnt == CNT_PRE) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_busy    = r_busy;
    assign rf_we      = r_rfWe;
    assign rf_addr    = r_rfAddr;
    assign rf_wdata   = r_rfWdata;
    assign wb_timeout = r_timeout;

endmodule

// File: tb/tb_wb_source_sequencer.sv
// Directed testbench for wb_source_sequencer. N_SRC is narrowed to 12 so
// select code 12 is the first out-of-range slot.
module tb_wb_source_sequencer;

    localparam int DATA_W   = 32;
    localparam int N_SRC    = 12;
    localparam int SEL_W    = 4;
    localparam int MAX_WAIT = 15;

    logic                    clk;
    logic                    reset_n;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_valid;
    logic [SEL_W-1:0]        sel;
    logic [4:0]              wb_dest;
    logic                    wb_req;
    logic                    wb_busy;
    logic                    rf_we;
    logic [4:0]              rf_addr;
    logic [DATA_W-1:0]       rf_wdata;
    logic                    wb_timeout;

    int assertCount = 0;
    int failCount   = 0;

    wb_source_sequencer #(
        .DATA_W    (DATA_W),
        .N_SRC     (N_SRC),
        .SEL_W     (SEL_W),
        .CONST_SRC (5),
        .CONST_VAL (32'd277),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .sel        (sel),
        .wb_dest    (wb_dest),
        .wb_req     (wb_req),
        .wb_busy    (wb_busy),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .wb_timeout (wb_timeout)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse wb_req for one cycle; returns in cycle t+1.
    task automatic applyStimulus(input logic [SEL_W-1:0] s, input logic [4:0] d);
        sel     = s;
        wb_dest = d;
        wb_req  = 1'b1;
        tick();
        wb_req  = 1'b0;
    endtask

    int weCount, weCycle, toCount, toCycle;
    logic [4:0]  capAddr;
    logic [31:0] capData;
    logic        busy16, busy17;

    // Directed scenarios.
    initial begin
        // Reset with random inputs
        reset_n = 1'b0;
        for (int k = 0; k < N_SRC; k++) src_data[k*DATA_W +: DATA_W] = $urandom();
        src_valid = N_SRC'($urandom());
        sel       = SEL_W'($urandom());
        wb_dest   = 5'($urandom());
        wb_req    = 1'b1;
        #12;
        checkOutput("rst_busy", wb_busy, 0);
        checkOutput("rst_we", rf_we, 0);
        checkOutput("rst_addr", rf_addr, 0);
        checkOutput("rst_wdata", rf_wdata, 0);
        checkOutput("rst_timeout", wb_timeout, 0);
        tick();
        wb_req  = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("idle_we", rf_we, 0);
        end

        // Immediate source
        src_valid = '0;
        src_data[0*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        src_valid[0] = 1'b1;
        applyStimulus(4'd0, 5'd9);
        checkOutput("alu_t1_busy", wb_busy, 1);
        checkOutput("alu_t1_we", rf_we, 0);
        tick();
        checkOutput("alu_t2_we", rf_we, 1);
        checkOutput("alu_t2_addr", rf_addr, 9);
        checkOutput("alu_t2_data", rf_wdata, 32'hDEAD_BEEF);
        tick();
        checkOutput("alu_t3_we", rf_we, 0);
        checkOutput("alu_t3_busy", wb_busy, 0);

        // Delayed Hi with an ignored second request
        src_valid = '0;
        src_data[2*DATA_W +: DATA_W] = 32'h1234_5678;
        sel = 4'd2; wb_dest = 5'd17; wb_req = 1'b1;
        weCount = 0; weCycle = 0; capAddr = '0; capData = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (rf_we) begin
                weCount++;
                if (weCycle == 0) begin
                    weCycle = c;
                    capAddr = rf_addr;
                    capData = rf_wdata;
                end
            end
            case (c)
                1: wb_req = 1'b0;
                2: begin wb_req = 1'b1; sel = 4'd0; wb_dest = 5'd3; end
                3: wb_req = 1'b0;
                4: src_valid[2] = 1'b1;
                default: ;
            endcase
        end
        checkOutput("hi_we_count", weCount, 1);
        checkOutput("hi_we_cycle", weCycle, 5);
        checkOutput("hi_addr", capAddr, 17);
        checkOutput("hi_data", capData, 32'h1234_5678);
        checkOutput("hi_busy_end", wb_busy, 0);

        // Timeout on a never-valid Lo
        src_valid = '0;
        sel = 4'd3; wb_dest = 5'd4; wb_req = 1'b1;
        toCount = 0; toCycle = 0; weCount = 0; busy16 = 1'b0; busy17 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) wb_req = 1'b0;
            if (wb_timeout) begin
                toCount++;
                if (toCycle == 0) toCycle = c;
            end
            if (rf_we) weCount++;
            if (c == 16) busy16 = wb_busy;
            if (c == 17) busy17 = wb_busy;
        end
        checkOutput("to_count", toCount, 1);
        checkOutput("to_cycle", toCycle, 16);
        checkOutput("to_no_write", weCount, 0);
        checkOutput("to_busy_t16", busy16, 1);
        checkOutput("to_busy_t17", busy17, 0);

        // Out-of-range slot, constant slot, $zero destination
        src_valid = '0;
        src_data[5*DATA_W +: DATA_W]  = 32'hFFFF_FFFF;
        src_data[11*DATA_W +: DATA_W] = 32'hA5A5_A5A5;
        applyStimulus(4'd12, 5'd7);
        tick();
        checkOutput("oor_we", rf_we, 1);
        checkOutput("oor_addr", rf_addr, 7);
        checkOutput("oor_data", rf_wdata, 0);
        tick();
        applyStimulus(4'd5, 5'd6);
        tick();
        checkOutput("const_we", rf_we, 1);
        checkOutput("const_addr", rf_addr, 6);
        checkOutput("const_data", rf_wdata, 32'd277);
        tick();
        src_valid[0] = 1'b1;
        applyStimulus(4'd0, 5'd0);
        checkOutput("zero_t1_busy", wb_busy, 1);
        tick();
        checkOutput("zero_t2_we", rf_we, 0);
        checkOutput("zero_t2_busy", wb_busy, 1);
        tick();
        checkOutput("zero_t3_we", rf_we, 0);
        checkOutput("zero_t3_busy", wb_busy, 0);

        // Asynchronous reset while waiting
        src_valid = '0;
        applyStimulus(4'd3, 5'd8);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", wb_busy, 0);
        checkOutput("mid_rst_we", rf_we, 0);
        checkOutput("mid_rst_addr", rf_addr, 0);
        checkOutput("mid_rst_wdata", rf_wdata, 0);
        checkOutput("mid_rst_timeout", wb_timeout, 0);
        tick();
        reset_n = 1'b1;
        src_data[3*DATA_W +: DATA_W] = 32'hCAFE_F00D;
        src_valid[3] = 1'b1;
        applyStimulus(4'd3, 5'd21);
        checkOutput("post_rst_busy", wb_busy, 1);
        tick();
        checkOutput("post_rst_we", rf_we, 1);
        checkOutput("post_rst_addr", rf_addr, 21);
        checkOutput("post_rst_data", rf_wdata, 32'hCAFE_F00D);
        tick();
        checkOutput("post_rst_we_off", rf_we, 0);
        checkOutput("post_rst_busy_off", wb_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
